// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage data-bus master and the lane aligner:
//   - AHB-Lite HTRANS and HSIZE codes
//   - bus master FSM state encoding
//   - decoded load/store kind (direction, size, zero-extension)
//   - helpers that decode the pipeline's one-hot kind flags and check alignment
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_ERR
    } state_e;

    // Decoded request kind. zext only has meaning for loads.
    typedef struct packed {
        logic   valid;
        logic   write;
        logic   zext;
        hsize_e size;
    } kind_t;

    // Collapse the one-hot flags into one kind. If several flags are set the
    // widest access wins, a store beats a load of the same width, and the
    // signed load form beats the unsigned one.
    function automatic kind_t decode_kind(
        input logic ld_byte, input logic ld_hw, input logic ld_word,
        input logic ld_bu,   input logic ld_hu,
        input logic st_byte, input logic st_hw, input logic st_word
    );
        kind_t k;
        k = '{valid: 1'b0, write: 1'b0, zext: 1'b0, size: HSIZE_WORD};
        if (st_word || ld_word) begin
            k.valid = 1'b1;
            k.write = st_word;
            k.size  = HSIZE_WORD;
        end else if (st_hw || ld_hw || ld_hu) begin
            k.valid = 1'b1;
            k.write = st_hw;
            k.zext  = !st_hw && !ld_hw;
            k.size  = HSIZE_HALF;
        end else if (st_byte || ld_byte || ld_bu) begin
            k.valid = 1'b1;
            k.write = st_byte;
            k.zext  = !st_byte && !ld_byte;
            k.size  = HSIZE_BYTE;
        end
        return k;
    endfunction

    function automatic logic is_misaligned(input hsize_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            HSIZE_HALF: bad = addr_lo[0];
            HSIZE_WORD: bad = (addr_lo != 2'b00);
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for a 32-bit little-endian bus.
//   size        in   access size (byte / half / word)
//   zext        in   1 = zero-extend loads, 0 = sign-extend
//   addr_lo     in   address bits [1:0] selecting the lane
//   wdata       in   right-aligned store data
//   rdata       in   raw bus read data
//   wdata_lanes out  store data replicated onto every lane of its size
//   rdata_ext   out  selected load lane, extended to 32 bits
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_pkg::*;
(
    input  hsize_e      size,
    input  logic        zext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statements can leave it unassigned (latch).
        wdata_lanes = wdata;
        rdata_ext   = rdata;

        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            HSIZE_BYTE: begin
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = zext ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            end
            HSIZE_HALF: begin
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = zext ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            end
            default: begin
                wdata_lanes = wdata;
                rdata_ext   = rdata;
            end
        endcase
    end

endmodule

// File: rtl/ahb_dmem_master.sv
// ---------------------------------------------------------------------------
// ahb_dmem_master
// Turns one MEM-stage load/store into a single AHB-Lite NONSEQ transfer and
// stalls the pipeline until it completes or fails.
//   clk, rst            clock, synchronous active-high reset
//   i_start             request valid from the MEM stage
//   i_addr, i_wdata     byte address, right-aligned store data
//   i_ld_* / i_st_*     one-hot load/store kind flags
//   o_stall             pipeline freeze while a request is in flight
//   o_rdata             extended load result (valid with o_done)
//   o_done, o_err       one-cycle completion / error pulses
//   HADDR..HWDATA       AHB-Lite master outputs
//   HRDATA, HREADY,
//   HRESP               AHB-Lite slave responses
// ---------------------------------------------------------------------------
module ahb_dmem_master
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_ld_byte,
    input  logic        i_ld_hw,
    input  logic        i_ld_word,
    input  logic        i_ld_bu,
    input  logic        i_ld_hu,
    input  logic        i_st_byte,
    input  logic        i_st_hw,
    input  logic        i_st_word,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    state_e           state;
    kind_t            req_kind;
    logic             zext_q;
    hsize_e           size_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      store_lanes;
    logic [31:0]      load_ext;

    assign req_kind = decode_kind(i_ld_byte, i_ld_hw, i_ld_word, i_ld_bu, i_ld_hu,
                                  i_st_byte, i_st_hw, i_st_word);

    // The stall must rise in the very cycle the request is presented, so it
    // cannot wait for the state register.
    assign o_stall = (state == ST_IDLE && i_start) || state == ST_ADDR || state == ST_DATA;

    // HADDR holds the latched address for the whole transfer, so its low bits
    // select the lanes.
    mem_lane_align u_lane_align (
        .size        (size_q),
        .zext        (zext_q),
        .addr_lo     (HADDR[1:0]),
        .wdata       (wdata_q),
        .rdata       (HRDATA),
        .wdata_lanes (store_lanes),
        .rdata_ext   (load_ext)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the request latches are reset along with the control state;
            // they are a handful of flops, not a memory array, so the cost is nil.
            state    <= ST_IDLE;
            HTRANS   <= HTRANS_IDLE;
            HADDR    <= '0;
            HWRITE   <= 1'b0;
            HSIZE    <= HSIZE_WORD;
            HWDATA   <= '0;
            o_rdata  <= '0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            wait_cnt <= '0;
            zext_q   <= 1'b0;
            size_q   <= HSIZE_WORD;
            wdata_q  <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (!req_kind.valid || is_misaligned(req_kind.size, i_addr[1:0])) begin
                            // Rejected before any bus activity.
                            state <= ST_ERR;
                            o_err <= 1'b1;
                        end else begin
                            state    <= ST_ADDR;
                            HTRANS   <= HTRANS_NONSEQ;
                            HADDR    <= i_addr;
                            HWRITE   <= req_kind.write;
                            HSIZE    <= req_kind.size;
                            size_q   <= req_kind.size;
                            zext_q   <= req_kind.zext;
                            wdata_q  <= i_wdata;
                            wait_cnt <= '0;
                        end
                    end
                end
                ST_ADDR: begin
                    // Address-phase outputs simply hold while HREADY is low.
                    if (HREADY) begin
                        state  <= ST_DATA;
                        HTRANS <= HTRANS_IDLE;
                        if (HWRITE) begin
                            HWDATA <= store_lanes;
                        end
                    end
                end
                ST_DATA: begin
                    if (HRESP) begin
                        // React on the first cycle of the two-cycle error response.
                        state <= ST_ERR;
                        o_err <= 1'b1;
                    end else if (HREADY) begin
                        state  <= ST_RESP;
                        o_done <= 1'b1;
                        if (!HWRITE) begin
                            o_rdata <= load_ext;
                        end
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th wait cycle.
                        state <= ST_ERR;
                        o_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dmem_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_dmem_master
// Directed bench for ahb_dmem_master. Expected completions (done/err and the
// load result) are queued when a request is issued and compared when the
// master reports completion. Inputs are driven and outputs sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_dmem_master;

    localparam int TIMEOUT = 16;

    typedef enum {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} op_e;

    typedef struct {
        bit          is_err;
        bit          chk_rdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata = '0;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    // {st_word, st_hw, st_byte, ld_hu, ld_bu, ld_word, ld_hw, ld_byte}
    logic [7:0]  flags;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_done;
    logic        o_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    always #5 clk = ~clk;

    ahb_dmem_master #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_ld_byte (flags[0]),
        .i_ld_hw   (flags[1]),
        .i_ld_word (flags[2]),
        .i_ld_bu   (flags[3]),
        .i_ld_hu   (flags[4]),
        .i_st_byte (flags[5]),
        .i_st_hw   (flags[6]),
        .i_st_word (flags[7]),
        .o_stall   (o_stall),
        .o_rdata   (o_rdata),
        .o_done    (o_done),
        .o_err     (o_err),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] flags_of(input op_e op);
        case (op)
            OP_LB:   return 8'b0000_0001;
            OP_LH:   return 8'b0000_0010;
            OP_LW:   return 8'b0000_0100;
            OP_LBU:  return 8'b0000_1000;
            OP_LHU:  return 8'b0001_0000;
            OP_SB:   return 8'b0010_0000;
            OP_SH:   return 8'b0100_0000;
            default: return 8'b1000_0000;
        endcase
    endfunction

    function automatic bit is_store(input op_e op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [2:0] exp_size(input op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'b000;
            OP_LH, OP_LHU, OP_SH: return 3'b001;
            default:              return 3'b010;
        endcase
    endfunction

    // Little-endian lane model: shift the wanted lane down to bit 0.
    function automatic logic [31:0] exp_load(input op_e op, input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] sh;
        case (op)
            OP_LB: begin
                sh = rd >> {a, 3'b000};
                return {{24{sh[7]}}, sh[7:0]};
            end
            OP_LBU: begin
                sh = rd >> {a, 3'b000};
                return {24'h0, sh[7:0]};
            end
            OP_LH: begin
                sh = rd >> {a[1], 4'b0000};
                return {{16{sh[15]}}, sh[15:0]};
            end
            OP_LHU: begin
                sh = rd >> {a[1], 4'b0000};
                return {16'h0, sh[15:0]};
            end
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input op_e op, input logic [31:0] w);
        case (op)
            OP_SB:   return {4{w[7:0]}};
            OP_SH:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_done_err"}, {30'b0, o_done, o_err}, e.is_err ? 32'd1 : 32'd2);
        if (e.chk_rdata) check({tag, "_rdata"}, o_rdata, e.rdata);
    endtask

    // mode 0: completes OKAY after data_waits wait states
    // mode 1: HRESP error after data_waits wait states
    // mode 2: HREADY never returns (timeout)
    task automatic run_txn(input string tag, input logic [7:0] flg, input op_e op,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int addr_waits,
                           input int data_waits, input int mode);
        exp_t e;
        int   stall_n = 0;
        int   exp_stall;
        int   n_data;
        bit   last;
        e.is_err    = (mode != 0);
        e.chk_rdata = (mode != 0) || !is_store(op);
        if (mode == 0 && !is_store(op)) model_rdata = exp_load(op, addr[1:0], rdata);
        e.rdata = model_rdata;
        sb_q.push_back(e);
        n_data    = (mode == 2) ? TIMEOUT : data_waits + 1;
        exp_stall = 2 + addr_waits + n_data;

        @(negedge clk);
        i_start = 1'b1; flags = flg; i_addr = addr; i_wdata = wdata;
        HREADY = 1'b1; HRESP = 1'b0;
        #1;
        check({tag, "_stall_req"}, {31'b0, o_stall}, 32'd1);
        if (o_stall) stall_n++;

        for (int i = 0; i <= addr_waits; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // Busy-time input changes must be ignored.
                i_start = 1'b0; flags = '0; i_addr = $urandom; i_wdata = $urandom;
            end
            check({tag, "_htrans_addr"}, {30'b0, HTRANS}, 32'd2);
            check({tag, "_haddr"}, HADDR, addr);
            check({tag, "_hwrite"}, {31'b0, HWRITE}, {31'b0, is_store(op)});
            check({tag, "_hsize"}, {29'b0, HSIZE}, {29'b0, exp_size(op)});
            if (o_stall) stall_n++;
            HREADY = (i == addr_waits);
            HRDATA = $urandom;
        end

        for (int i = 0; i < n_data; i++) begin
            @(negedge clk);
            check({tag, "_htrans_data"}, {30'b0, HTRANS}, 32'd0);
            check({tag, "_no_early_end"}, {30'b0, o_done, o_err}, 32'd0);
            if (is_store(op)) check({tag, "_hwdata"}, HWDATA, exp_wdata(op, wdata));
            if (o_stall) stall_n++;
            last = (i == n_data - 1);
            HREADY = (mode == 0) && last;
            HRESP  = (mode == 1) && last;
            HRDATA = (mode == 0 && last) ? rdata : $urandom;
        end

        @(negedge clk);
        pop_and_check(tag);
        check({tag, "_stall_end"}, {31'b0, o_stall}, 32'd0);
        check({tag, "_stall_cycles"}, stall_n, exp_stall);
        HREADY = 1'b1; HRESP = 1'b0;

        @(negedge clk);
        check({tag, "_pulse_once"}, {30'b0, o_done, o_err}, 32'd0);
        check({tag, "_htrans_idle"}, {30'b0, HTRANS}, 32'd0);
    endtask

    // Requests rejected in IDLE: error pulse next cycle, no bus activity.
    task automatic reject_req(input string tag, input logic [7:0] flg, input logic [31:0] addr);
        exp_t e;
        e.is_err = 1'b1; e.chk_rdata = 1'b1; e.rdata = model_rdata;
        sb_q.push_back(e);
        @(negedge clk);
        i_start = 1'b1; flags = flg; i_addr = addr; i_wdata = $urandom;
        #1;
        check({tag, "_stall_req"}, {31'b0, o_stall}, 32'd1);
        check({tag, "_htrans0"}, {30'b0, HTRANS}, 32'd0);
        @(negedge clk);
        i_start = 1'b0; flags = '0;
        pop_and_check(tag);
        check({tag, "_htrans1"}, {30'b0, HTRANS}, 32'd0);
        check({tag, "_stall_end"}, {31'b0, o_stall}, 32'd0);
        @(negedge clk);
        check({tag, "_pulse_once"}, {30'b0, o_done, o_err}, 32'd0);
        check({tag, "_htrans2"}, {30'b0, HTRANS}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; flags = '0; i_addr = '0; i_wdata = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_htrans", {30'b0, HTRANS}, 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hwrite", {31'b0, HWRITE}, 32'd0);
        check("rst_hsize", {29'b0, HSIZE}, 32'd2);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_done_err", {30'b0, o_done, o_err}, 32'd0);
        check("rst_stall", {31'b0, o_stall}, 32'd0);

        // Main loads and stores
        run_txn("lw_0wait",  flags_of(OP_LW),  OP_LW,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        run_txn("lb_103",    flags_of(OP_LB),  OP_LB,  32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 0);
        check("lb_103_const", o_rdata, 32'hFFFF_FF80);
        run_txn("lbu_103",   flags_of(OP_LBU), OP_LBU, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0, 0, 0);
        check("lbu_103_const", o_rdata, 32'h0000_0080);
        run_txn("sh_2wait",  flags_of(OP_SH),  OP_SH,  32'h0000_0202, 32'h0000_ABCD, 32'h0, 0, 2, 0);
        run_txn("lh_102",    flags_of(OP_LH),  OP_LH,  32'h0000_0102, 32'h0, 32'h8001_7FFF, 1, 0, 0);
        run_txn("lhu_100",   flags_of(OP_LHU), OP_LHU, 32'h0000_0100, 32'h0, 32'h8001_F00F, 0, 1, 0);
        run_txn("sb_001",    flags_of(OP_SB),  OP_SB,  32'h0000_0001, 32'h1234_5678, 32'h0, 2, 1, 0);
        run_txn("sw_300",    flags_of(OP_SW),  OP_SW,  32'h0000_0300, 32'hCAFE_F00D, 32'h0, 0, 0, 0);
        run_txn("lb_lane1",  flags_of(OP_LB),  OP_LB,  32'h0000_0101, 32'h0, 32'h0000_9A00, 0, 0, 0);

        // Multiple kind flags: signed beats unsigned, word beats byte
        run_txn("prio_lb_lbu", flags_of(OP_LB) | flags_of(OP_LBU), OP_LB,
                32'h0000_0102, 32'h0, 32'h00C3_0000, 0, 0, 0);
        run_txn("prio_lw_lb",  flags_of(OP_LW) | flags_of(OP_LB),  OP_LW,
                32'h0000_0104, 32'h0, 32'h1357_9BDF, 0, 0, 0);

        // Rejected requests
        reject_req("lw_misalign", flags_of(OP_LW), 32'h0000_0101);
        reject_req("sh_misalign", flags_of(OP_SH), 32'h0000_0201);
        reject_req("no_kind",     8'h00,           32'h0000_0100);

        // Bus errors and timeout leave o_rdata untouched
        run_txn("hresp_err", flags_of(OP_LW), OP_LW, 32'h0000_0400, 32'h0, 32'h0, 0, 1, 1);
        run_txn("timeout",   flags_of(OP_LW), OP_LW, 32'h0000_0500, 32'h0, 32'h0, 0, 0, 2);

        // Reset while in the data phase
        @(negedge clk);
        i_start = 1'b1; flags = flags_of(OP_LW); i_addr = 32'h0000_0600; HREADY = 1'b1;
        @(negedge clk);
        i_start = 1'b0; flags = '0;
        check("rst_mid_in_addr", {30'b0, HTRANS}, 32'd2);
        @(negedge clk);
        check("rst_mid_in_data", {31'b0, o_stall}, 32'd1);
        HREADY = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_mid_htrans", {30'b0, HTRANS}, 32'd0);
        check("rst_mid_stall", {31'b0, o_stall}, 32'd0);
        check("rst_mid_done_err", {30'b0, o_done, o_err}, 32'd0);
        model_rdata = '0;
        rst = 1'b0; HREADY = 1'b1; HRDATA = 32'h5555_AAAA;
        @(negedge clk);
        check("rst_mid_ignored", {30'b0, o_done, o_err}, 32'd0);
        check("rst_mid_rdata", o_rdata, 32'd0);
        run_txn("lw_after_rst", flags_of(OP_LW), OP_LW, 32'h0000_0700, 32'h0, 32'h0BAD_F00D, 0, 0, 0);

        check("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
